// File: rtl/snake_engine.sv
// snake_engine: single-snake update engine with a circular body buffer,
// grid-memory read/write port, fruit handshake and per-fruit speed-up.
module snake_engine #(
    parameter int MAPA_WIDTH  = 40,
    parameter int MAPA_HEIGHT = 30,
    parameter int COORD_W     = 10,
    parameter int MAX_LEN     = 128,
    parameter int START_X     = 10,
    parameter int START_Y     = 10,
    parameter int TICK_INIT   = 50000000,
    parameter int TICK_MIN    = 5000000,
    parameter int TICK_STEP   = 2000000,
    parameter int SCORE_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pause,
    input  logic [1:0]                 cobra_dir,
    output logic                       map_renable,
    output logic [COORD_W-1:0]         map_rx,
    output logic [COORD_W-1:0]         map_ry,
    input  logic [1:0]                 map_rdata,
    output logic                       map_wenable,
    output logic [COORD_W-1:0]         map_wx,
    output logic [COORD_W-1:0]         map_wy,
    output logic [1:0]                 map_wdata,
    output logic                       fruta_req,
    input  logic                       fruta_ack,
    input  logic [COORD_W-1:0]         fruta_x,
    input  logic [COORD_W-1:0]         fruta_y,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic [SCORE_W-1:0]         score,
    output logic                       game_over
);
    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TICK_INIT + 1);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(MAPA_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(MAPA_HEIGHT - 1);
    localparam logic [LW-1:0] LEN_FULL = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        S_CLEAR, S_FRUIT, S_IDLE, S_MOVE,
        S_CHECK, S_HEAD, S_ERASE, S_OVER
    } state_t;

    state_t state, state_n;

    logic [COORD_W-1:0] cx, cy, hx, hy, nx, ny, tail_x, tail_y;
    logic [COORD_W-1:0] mx, my;
    logic [COORD_W-1:0] seg_x [MAX_LEN];
    logic [COORD_W-1:0] seg_y [MAX_LEN];
    logic [PW-1:0]      head_ptr, tail_ptr, head_nxt;
    logic [TW-1:0]      tick_cnt, period;
    logic [1:0]         heading, dir_eff;
    logic               grow, eat_full, tick_hit, hit, full;

    assign head_nxt  = head_ptr + PW'(1);
    assign tick_hit  = (tick_cnt == period - TW'(1));
    assign full      = (length == LEN_FULL);
    assign game_over = (state == S_OVER);

    // a cell holding snake is harmless only if it is the tail about to vacate
    assign hit = (map_rdata == 2'b11) ||
                 (map_rdata == 2'b01 &&
                  !(nx == seg_x[tail_ptr] && ny == seg_y[tail_ptr]));

    always_comb begin
        dir_eff = cobra_dir;
        if (length > LW'(1) && cobra_dir == {heading[1], ~heading[0]})
            dir_eff = heading;
        mx = hx;
        my = hy;
        unique case (dir_eff)
            2'd0: my = (hy == '0) ? Y_LAST : hy - COORD_W'(1);
            2'd1: my = (hy == Y_LAST) ? '0 : hy + COORD_W'(1);
            2'd2: mx = (hx == '0) ? X_LAST : hx - COORD_W'(1);
            2'd3: mx = (hx == X_LAST) ? '0 : hx + COORD_W'(1);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_CLEAR;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_CLEAR: if (cx == X_LAST && cy == Y_LAST) state_n = S_FRUIT;
            S_FRUIT: if (fruta_ack) state_n = S_IDLE;
            S_IDLE:  if (!pause && tick_hit) state_n = S_MOVE;
            S_MOVE:  state_n = S_CHECK;
            S_CHECK: state_n = hit ? S_OVER : S_HEAD;
            S_HEAD:  state_n = (grow && !full) ? S_FRUIT : S_ERASE;
            S_ERASE: state_n = eat_full ? S_FRUIT : S_IDLE;
            S_OVER:  state_n = S_OVER;
            default: state_n = S_CLEAR;
        endcase
    end

    // strobes are gated by reset so an asserted reset silences the port at once
    always_comb begin
        map_renable = 1'b0;
        map_rx      = '0;
        map_ry      = '0;
        map_wenable = 1'b0;
        map_wx      = '0;
        map_wy      = '0;
        map_wdata   = 2'b00;
        fruta_req   = 1'b0;
        if (reset) begin
            unique case (state)
                S_CLEAR: begin
                    map_wenable = 1'b1;
                    map_wx      = cx;
                    map_wy      = cy;
                    map_wdata   = (cx == COORD_W'(START_X) &&
                                   cy == COORD_W'(START_Y)) ? 2'b01 : 2'b00;
                end
                S_FRUIT: begin
                    fruta_req   = !fruta_ack;
                    map_wenable = fruta_ack;
                    map_wx      = fruta_x;
                    map_wy      = fruta_y;
                    map_wdata   = 2'b10;
                end
                S_MOVE: begin
                    map_renable = 1'b1;
                    map_rx      = mx;
                    map_ry      = my;
                end
                S_HEAD: begin
                    map_wenable = 1'b1;
                    map_wx      = nx;
                    map_wy      = ny;
                    map_wdata   = 2'b01;
                end
                S_ERASE: begin
                    map_wenable = !(tail_x == hx && tail_y == hy);
                    map_wx      = tail_x;
                    map_wy      = tail_y;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx       <= '0;
            cy       <= '0;
            tick_cnt <= '0;
            period   <= TW'(TICK_INIT);
            heading  <= 2'd3;
            hx       <= COORD_W'(START_X);
            hy       <= COORD_W'(START_Y);
            nx       <= '0;
            ny       <= '0;
            tail_x   <= '0;
            tail_y   <= '0;
            grow     <= 1'b0;
            eat_full <= 1'b0;
            head_ptr <= '0;
            tail_ptr <= '0;
            length   <= LW'(1);
            score    <= '0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    if (cx == X_LAST) begin
                        cx <= '0;
                        cy <= cy + COORD_W'(1);
                    end else begin
                        cx <= cx + COORD_W'(1);
                    end
                end
                S_IDLE: if (!pause) tick_cnt <= tick_hit ? '0 : tick_cnt + TW'(1);
                S_MOVE: begin
                    heading <= dir_eff;
                    nx      <= mx;
                    ny      <= my;
                end
                S_CHECK: grow <= (map_rdata == 2'b10);
                S_HEAD: begin
                    head_ptr <= head_nxt;
                    hx       <= nx;
                    hy       <= ny;
                    // at full length the new head overwrites the tail slot
                    tail_x   <= seg_x[tail_ptr];
                    tail_y   <= seg_y[tail_ptr];
                    eat_full <= grow && full;
                    if (grow) begin
                        if (score != '1) score <= score + SCORE_W'(1);
                        period <= (period > TW'(TICK_MIN + TICK_STEP)) ?
                                  period - TW'(TICK_STEP) : TW'(TICK_MIN);
                        if (!full) length <= length + LW'(1);
                    end
                end
                S_ERASE: tail_ptr <= tail_ptr + PW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= COORD_W'(START_X);
                seg_y[i] <= COORD_W'(START_Y);
            end
        end else if (state == S_HEAD) begin
            seg_x[head_nxt] <= nx;
            seg_y[head_nxt] <= ny;
        end
    end
endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
Parametrised successor to the single-snake update FSM. Owns the snake body as a circular segment buffer and the grid-memory read/write port. Advances the snake on a programmable tick, detects fruit, self and obstacle collisions, and grows the snake. Requests new fruit through a req/ack handshake and speeds up per fruit eaten. Sits between the input/direction logic, the fruit generator and the dual-port map RAM read by the VGA renderer.

Parameters:
MAPA_WIDTH, 40, grid columns
MAPA_HEIGHT, 30, grid rows
COORD_W, 10, coordinate width
MAX_LEN, 128, body buffer depth (power of 2)
START_X, 10, initial head column
START_Y, 10, initial head row
TICK_INIT, 50000000, clocks per move after reset
TICK_MIN, 5000000, floor for clocks per move
TICK_STEP, 2000000, tick reduction per fruit eaten
SCORE_W, 16, score width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pause  in  1  high holds the snake in IDLE (tick counter frozen)
cobra_dir  in  2  0 up, 1 down, 2 left, 3 right
map_renable  out  1  grid read strobe
map_rx, map_ry  out  COORD_W  read address
map_rdata  in  2  read data, valid the cycle after map_renable
map_wenable  out  1  grid write strobe
map_wx, map_wy  out  COORD_W  write address
map_wdata  out  2  write data; 00 empty, 01 snake, 10 fruit, 11 obstacle
fruta_req  out  1  new-fruit request
fruta_ack  in  1  fruit coordinate valid
fruta_x, fruta_y  in  COORD_W  fruit coordinate
length  out  log2(MAX_LEN)+1  current snake length
score  out  SCORE_W  fruits eaten, saturating at all-ones
game_over  out  1  sticky until reset

Behaviour:
- Reset (async, low): all outputs 0. head=tail pointer=0; seg[0]=(START_X,START_Y); length=1; tick period=TICK_INIT; heading=3; state CLEAR.
- CLEAR: one write per cycle, raster order (x fastest), MAPA_WIDTH*MAPA_HEIGHT cycles. Data is 01 at (START_X,START_Y), 00 elsewhere. Then FRUIT_REQ.
- FRUIT_REQ: fruta_req=1 until fruta_ack is sampled high. In the ack cycle, drop req and write 10 at (fruta_x,fruta_y). Next state IDLE. No timeout. The generator guarantees an empty cell.
- IDLE: counter increments unless pause=1. When counter==period-1, clear the counter and go to MOVE.
- MOVE: latch cobra_dir into heading, except when it is the exact reverse of the current heading and length>1 (request ignored). Compute next head with wrap: 0→MAPA_*-1 and MAPA_*-1→0. Assert map_renable with the next head for one cycle. Next state CHECK.
- CHECK (rdata valid):
  - 11 → GAME_OVER.
  - 01 → GAME_OVER, unless next head equals the tail segment (tail vacates this move); then treat as 00.
  - 10 → grow=1.
  - 00 → grow=0.
- WRITE_HEAD: write 01 at next head. head ptr+1 mod MAX_LEN; store coordinate.
  - If grow and length<MAX_LEN: length+1, skip the erase.
  - If grow and length==MAX_LEN: no growth, erase the tail normally.
  - Either grow case: score+1 (saturating); period=max(period-TICK_STEP, TICK_MIN); next FRUIT_REQ.
  - Otherwise next ERASE_TAIL.
- ERASE_TAIL: write 00 at tail segment, tail ptr+1. Skip the write if the tail coordinate equals the new head (tail-chase case). Next IDLE.
- Full-length fruit path: WRITE_HEAD → ERASE_TAIL → FRUIT_REQ.
- GAME_OVER: game_over=1, no further writes or reads. Held until reset.
- Write strobe is high for exactly one cycle per write. Read and write never occur in the same cycle.
- Latency from tick expiry to head write: 3 cycles (MOVE, CHECK, WRITE_HEAD).
- Reset mid-operation: abort immediately. Pending fruta_req drops; CLEAR restarts.

Test Plan:
- Reset release → exactly 1200 write strobes (40x30), only (10,10) written 01; fruta_req rises. Ack with (13,13) → write 10 at (13,13).
- TICK_INIT=4, cobra_dir=3, map_rdata=00 → head writes at (11,10),(12,10) 5+ cycles apart, each followed by a 00 write to the previous cell; length stays 1.
- Head at (39,5) moving right → read/write at (0,5). Head at (5,0) moving up → (5,29).
- map_rdata=10 on three moves → length 4, score 3, period 50M→44M, no tail erase on those moves. map_rdata=01 at a non-tail cell → game_over=1, no further strobes.
- length=2 heading right, cobra_dir=2 → heading stays right. MAX_LEN=4 full and eats fruit → length stays 4, score+1, tail erased.
- pause=1 for 100 cycles mid-count → move delayed exactly 100 cycles. Reset low during FRUIT_REQ → outputs 0 asynchronously, CLEAR restarts.
